// File: rtl/kmeans_k3n3_controller.sv
// rtl/kmeans_k3n3_controller.sv - k-means (k=3, 3-D) iteration sequencer
// Sweeps the sample RAM, accumulates per-centroid sums and counts, and updates centroids by serial division.
module kmeans_k3n3_controller #(
  parameter int input_data_width         = 8,
  parameter int input_data_qty_bit_width = 8,
  parameter int input_data_qty           = 256,
  parameter int pipeline_latency         = 6,
  parameter int max_iterations           = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [9*input_data_width-1:0]             k_init,
  output logic [input_data_qty_bit_width-1:0]       rd_address,
  input  logic [1:0]                                selected_centroid,
  input  logic [input_data_width-1:0]               output_data0,
  input  logic [input_data_width-1:0]               output_data1,
  input  logic [input_data_width-1:0]               output_data2,
  output logic [9*input_data_width-1:0]             centroids,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      converged,
  output logic [7:0]                                iteration
);
  localparam int W   = input_data_width;
  localparam int AW  = input_data_qty_bit_width;
  localparam int L   = pipeline_latency;
  localparam int SW  = W + AW + 1;
  localparam int CW  = AW + 1;
  localparam int SBW = $clog2(SW);
  localparam logic [AW-1:0]  LAST_ADDR  = AW'(input_data_qty - 1);
  localparam logic [7:0]     ITER_LIMIT = 8'(max_iterations);
  localparam logic [SBW-1:0] LAST_STEP  = SBW'(SW - 1);
  localparam logic [L-1:0]   TAIL_BIT   = L'(1 << (L - 1));

  typedef enum logic [2:0] {S_IDLE, S_PROC, S_DRAIN, S_DIV, S_UPDATE, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [L-1:0]   vpipe;
  logic [SW-1:0]  sum [9];
  logic [CW-1:0]  cnt [3];
  logic [9*W-1:0] next_cent;
  logic [3:0]     div_idx;
  logic [1:0]     div_c;
  logic [SBW-1:0] div_step;
  logic [SW-1:0]  div_q;
  logic [AW:0]    div_r;

  logic           issue, capture, drain_end, last_div, unchanged, clear_acc;
  logic [SW-1:0]  src_q, q_nxt;
  logic [AW:0]    src_r;
  logic [AW+1:0]  trial, divisor, r_nxt;
  logic           ge;
  logic           unused_rtop;

  assign issue       = (state == S_PROC);
  assign capture     = vpipe[L-1] && (selected_centroid != 2'd3) &&
                       ((state == S_PROC) || (state == S_DRAIN));
  assign drain_end   = ((vpipe & ~TAIL_BIT) == '0);
  assign last_div    = (div_idx == 4'd8) && (div_step == LAST_STEP);
  assign unchanged   = (next_cent == centroids);
  assign clear_acc   = ((state == S_IDLE) && start) || ((state == S_UPDATE) && (state_nxt == S_PROC));
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  // Restoring divider step; the first step of each quotient loads the dividend directly.
  always_comb begin
    div_c = 2'd2;
    if (div_idx < 4'd3)      div_c = 2'd0;
    else if (div_idx < 4'd6) div_c = 2'd1;
    src_q   = (div_step == '0) ? sum[div_idx] : div_q;
    src_r   = (div_step == '0) ? '0 : div_r;
    trial   = {src_r, src_q[SW-1]};
    divisor = {1'b0, cnt[div_c]};
    ge      = (trial >= divisor);
    r_nxt   = ge ? (trial - divisor) : trial;
    q_nxt   = {src_q[SW-2:0], ge};
  end
  assign unused_rtop = r_nxt[AW+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_PROC;
      S_PROC:   if (rd_address == LAST_ADDR) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_end) state_nxt = S_DIV;
      S_DIV:    if (last_div) state_nxt = S_UPDATE;
      S_UPDATE: begin
        if (unchanged || (iteration + 8'd1 == ITER_LIMIT)) state_nxt = S_DONE;
        else                                               state_nxt = S_PROC;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_address <= '0;
      centroids  <= '0;
      iteration  <= '0;
      converged  <= 1'b0;
      vpipe      <= '0;
      next_cent  <= '0;
      div_idx    <= '0;
      div_step   <= '0;
      div_q      <= '0;
      div_r      <= '0;
      for (int i = 0; i < 9; i++) sum[i] <= '0;
      for (int c = 0; c < 3; c++) cnt[c] <= '0;
    end else begin
      vpipe[0] <= issue;
      for (int i = 1; i < L; i++) vpipe[i] <= vpipe[i-1];

      case (state)
        S_IDLE: begin
          if (start) begin
            centroids  <= k_init;
            iteration  <= '0;
            converged  <= 1'b0;
            rd_address <= '0;
          end
        end
        S_PROC: rd_address <= (rd_address == LAST_ADDR) ? '0 : rd_address + AW'(1);
        S_DIV: begin
          div_q <= q_nxt;
          div_r <= r_nxt[AW:0];
          if (div_step == LAST_STEP) begin
            // An empty cluster keeps its previous position.
            next_cent[int'(div_idx)*W +: W] <= (cnt[div_c] == '0) ?
                centroids[int'(div_idx)*W +: W] : q_nxt[W-1:0];
            div_step <= '0;
            div_idx  <= (div_idx == 4'd8) ? 4'd0 : div_idx + 4'd1;
          end else begin
            div_step <= div_step + SBW'(1);
          end
        end
        S_UPDATE: begin
          centroids <= next_cent;
          iteration <= iteration + 8'd1;
          converged <= unchanged;
        end
        default: ;
      endcase

      if (clear_acc) begin
        for (int i = 0; i < 9; i++) sum[i] <= '0;
        for (int c = 0; c < 3; c++) cnt[c] <= '0;
      end else if (capture) begin
        for (int c = 0; c < 3; c++) begin
          if (selected_centroid == 2'(c)) begin
            sum[c*3]   <= sum[c*3]   + SW'(output_data0);
            sum[c*3+1] <= sum[c*3+1] + SW'(output_data1);
            sum[c*3+2] <= sum[c*3+2] + SW'(output_data2);
            cnt[c]     <= cnt[c] + CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: doc/kmeans_k3n3_controller.md
Name: kmeans_k3n3_controller

Overview:
Iteration sequencer for the 3-centroid, 3-dimension k-means datapath. It sweeps the input RAM read address, tracks which samples are in flight through the fixed-latency distance/compare pipeline, and accumulates per-centroid sums and counts. At the end of each pass it divides the sums by the counts with a serial divider and updates the centroid registers. It repeats until the centroids stop changing or an iteration limit is reached. It sits between the input data block and the pipeline and owns the live centroid values.

Parameters:
input_data_width, 8, bits per dimension (W)
input_data_qty_bit_width, 8, RAM address width (AW)
input_data_qty, 256, samples per pass; 1..2^AW
pipeline_latency, 6, cycles from rd_address issue to valid selected_centroid/output_data
max_iterations, 16, pass limit; 1..255

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begins a run when idle
k_init  in  9*W  initial centroids, {k2d2,k2d1,k2d0,k1d2,k1d1,k1d0,k0d2,k0d1,k0d0}; latched on accepted start
rd_address  out  AW  input RAM read address
selected_centroid  in  2  pipeline result; 0..2 valid, 3 is ignored
output_data0  in  W  dim-0 sample propagated by the pipeline
output_data1  in  W  dim-1 sample propagated by the pipeline
output_data2  in  W  dim-2 sample propagated by the pipeline
centroids  out  9*W  current centroids, same packing as k_init; driven to pipeline
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
converged  out  1  1 when the last run ended by convergence; held until next start
iteration  out  8  completed passes in current/last run

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. rd_address=0, centroids=0, busy=0, done=0, converged=0, iteration=0. Accumulators, counts, valid pipe and divider all clear. Reset asserted mid-run aborts the run with no done pulse.
- States: IDLE, PROC, DRAIN, DIV, UPDATE, DONE.
- IDLE: start=1 latches k_init into centroids, clears iteration and converged, clears accumulators, sets rd_address=0, sets busy=1, goes to PROC. start is ignored in every other state.
- PROC: one address is issued per cycle: 0, 1, ..., input_data_qty-1. A 1 is shifted into a pipeline_latency-deep valid shift register for each issued address; a 0 is shifted in all other cycles. After issuing input_data_qty-1 the block goes to DRAIN; rd_address returns to 0.
- Sample capture: in any cycle where the valid-pipe tail is 1 and selected_centroid<3, the block adds output_data0/1/2 to sum[sel][0..2] (width W+AW+1) and increments cnt[sel] (width AW+1). Capture applies in PROC and DRAIN. The first capture occurs pipeline_latency cycles after address 0 is issued.
- DRAIN: lasts until the valid pipe is empty (pipeline_latency cycles), then goes to DIV.
- DIV: restoring serial division, floor(sum/cnt), in the order k0d0..k2d2. Each quotient takes W+AW+1 cycles; all 9 take 9*(W+AW+1). When cnt=0 the quotient is the old centroid value (empty cluster keeps its position). The quotient is truncated to W bits; its value is always ≤ 2^W-1.
- UPDATE (1 cycle): new centroids are written to centroids and iteration increments.
  - If all 9 new values equal the old ones: converged=1, go to DONE.
  - Else if iteration+1 == max_iterations: converged=0, go to DONE.
  - Else: clear sums and counts, go to PROC.
- DONE (1 cycle): done=1 and busy=0 from the next cycle; return to IDLE. centroids, iteration and converged hold until the next start.
- Centroids are stable during PROC/DRAIN, so all in-flight samples of a pass use the same centroids.
- Pass length in cycles: input_data_qty + pipeline_latency + 9*(W+AW+1) + 1.

Test Plan:
- Convergence (input_data_qty=4, AW=2). Stimulus: points (0,0,0),(1,1,1),(10,10,10),(12,12,12); k_init k0=0, k1=1, k2=2; model returns sel 0,1,2,2. Required: after pass 1, k2=(11,11,11) with k0/k1 unchanged; pass 2 makes no change; done with converged=1, iteration=2.
- Empty cluster: every sample returns sel=0, with points (4,4,4) and (8,8,8). Required: k0=(6,6,6); k1 and k2 equal k_init; converged=1 at iteration=2.
- Iteration limit: max_iterations=3; model alternates assignment per pass so centroids keep changing. Required: done after exactly 3 passes; converged=0; iteration=3.
- Address/latency timing: trace rd_address 0..qty-1 on consecutive cycles; check first capture exactly 6 cycles after address 0; check busy deasserts in the cycle after the done pulse.
- Control robustness:
  - sel=3 injected on one sample: that sample is ignored and its count is not incremented.
  - start pulsed mid-PROC: ignored.
  - rst=0 mid-DIV: all outputs return to reset values immediately; no done pulse; a new start runs normally.
- Rounding: sums 7 over 2 samples. Required: result 3 (floor).
